// File: rtl/seg_display_mux.sv
// Time-multiplexes four BCD stopwatch digits onto a common-anode 4-digit 7-segment display.
// The minutes or seconds pair selected by sel blinks while adjust mode is active.
module seg_display_mux #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] min1,
   input  logic [3:0] min2,
   input  logic [2:0] sec1,
   input  logic [3:0] sec2,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          ref_wrap;
   logic          blank;
   logic [3:0]    digit;
   logic [3:0]    an_slot;
   logic [6:0]    seg_dec;

   always_comb begin
      ref_wrap      = (refresh_cnt_q == REF_LAST);
      refresh_cnt_d = ref_wrap ? '0 : refresh_cnt_q + 1'b1;
      idx_d         = ref_wrap ? idx_q + 2'd1 : idx_q;

      // Leaving adjust mode clears the blink state so re-entry starts with a visible half-period.
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (adj) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q;
         end
      end
   end

   always_comb begin
      digit   = sec2;
      an_slot = 4'b1110;
      case (idx_q)
         2'd0: begin digit = sec2;         an_slot = 4'b1110; end
         2'd1: begin digit = {1'b0, sec1}; an_slot = 4'b1101; end
         2'd2: begin digit = min2;         an_slot = 4'b1011; end
         2'd3: begin digit = {1'b0, min1}; an_slot = 4'b0111; end
         default: begin digit = sec2;      an_slot = 4'b1110; end
      endcase

      case (digit)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b0111111;
      endcase

      // idx[1] set means a minutes slot (2,3); clear means a seconds slot (0,1).
      blank = adj & blink_phase_q & (sel ? ~idx_q[1] : idx_q[1]);
      an_d  = blank ? 4'b1111 : an_slot;
      seg_d = blank ? 7'b1111111 : seg_dec;
      dp_d  = blank | (idx_q != 2'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt_q <= '0;
         idx_q         <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an_q          <= 4'b1111;
         seg_q         <= 7'b1111111;
         dp_q          <= 1'b1;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
